// File: rtl/dice_cgra_pkg.sv
// Shared types for the CGRA dispatch predicate-RF TID sequencer.
// Holds TID width, sequencer state encoding and delay-line entry layout.
package dice_cgra_pkg;

    localparam int DICE_NUM_TID = 512;
    localparam int DICE_ADDR_W  = $clog2(DICE_NUM_TID);
    localparam int DICE_MAX_LAT = 32;

    typedef logic [DICE_ADDR_W-1:0] tid_t;
    typedef logic [DICE_ADDR_W:0]   tid_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic valid;
        tid_t tid;
    } tid_entry_t;

    // base + idx, wrapping past the last thread slot back to slot 0
    function automatic tid_t tid_wrap(tid_t base, tid_cnt_t idx);
        tid_cnt_t sum;
        sum = {1'b0, base} + idx;
        if (sum >= tid_cnt_t'(DICE_NUM_TID)) begin
            sum = sum - tid_cnt_t'(DICE_NUM_TID);
        end
        return sum[DICE_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/dice_tid_delay_line.sv
// Variable-tap shift register that replays issued TIDs at writeback time.
// Tap 0 is a combinational bypass of the pushed entry.
module dice_tid_delay_line
    import dice_cgra_pkg::*;
#(
    parameter int  MAX_CGRA_LATENCY = DICE_MAX_LAT,
    localparam int LATW             = $clog2(MAX_CGRA_LATENCY + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            shift_en,
    input  tid_entry_t      push,
    input  logic [LATW-1:0] lat,
    output tid_entry_t      tap
);

    tid_entry_t line_q [MAX_CGRA_LATENCY:1];

    // advance one slot per non-stalled cycle; flush on reset or clear
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 1; i <= MAX_CGRA_LATENCY; i++) begin
                line_q[i] <= '0;
            end
        end else if (shift_en) begin
            line_q[1] <= push;
            for (int i = 2; i <= MAX_CGRA_LATENCY; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    // select the slot matching the configured latency
    always_comb begin
        tap = push;
        for (int i = 1; i <= MAX_CGRA_LATENCY; i++) begin
            if (lat == LATW'(i)) begin
                tap = line_q[i];
            end
        end
    end

endmodule

// File: rtl/dice_pred_rf_tid_sequencer.sv
// Streams a TID range onto RF read ports and replays each TID on the
// write ports after the CGRA latency, counted in non-stalled cycles.
module dice_pred_rf_tid_sequencer
    import dice_cgra_pkg::*;
#(
    parameter int  NUM_PORTS        = 16,
    parameter int  NUM_TID          = DICE_NUM_TID,
    parameter int  RF_ADDR_WIDTH    = $clog2(NUM_TID),
    parameter int  MAX_CGRA_LATENCY = DICE_MAX_LAT,
    localparam int LATW             = $clog2(MAX_CGRA_LATENCY + 1),
    localparam int INFW             = $clog2(MAX_CGRA_LATENCY + 2)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           start,
    input  logic [RF_ADDR_WIDTH-1:0]       tid_base,
    input  logic [RF_ADDR_WIDTH:0]         tid_count,
    input  logic [LATW-1:0]                cgra_latency,
    input  logic [NUM_PORTS-1:0]           port_rd_mask,
    input  logic [NUM_PORTS-1:0]           port_wr_mask,
    input  logic                           stall,
    output logic [NUM_PORTS-1:0]           rd_en,
    output logic [NUM_PORTS*RF_ADDR_WIDTH-1:0] rd_tid,
    output logic [NUM_PORTS-1:0]           wr_en,
    output logic [NUM_PORTS*RF_ADDR_WIDTH-1:0] wr_tid,
    output logic                           busy,
    output logic                           done
);

    seq_state_e state_q, state_d;

    tid_t                 base_q;
    tid_cnt_t             count_q;
    logic [LATW-1:0]      lat_q;
    logic [NUM_PORTS-1:0] rd_mask_q;
    logic [NUM_PORTS-1:0] wr_mask_q;

    tid_t                 base_e;
    tid_cnt_t             count_e;
    logic [LATW-1:0]      lat_e;
    logic [NUM_PORTS-1:0] rd_mask_e;
    logic [NUM_PORTS-1:0] wr_mask_e;

    tid_cnt_t        idx_q, idx_e;
    logic [INFW-1:0] infl_q, infl_d;

    logic accept;
    logic step;
    logic issuing;
    logic wb;
    logic last;

    tid_entry_t push;
    tid_entry_t tap;

    logic [NUM_PORTS-1:0] rd_en_q;
    logic [NUM_PORTS-1:0] wr_en_q;
    tid_t                 rd_tid_q;
    tid_t                 wr_tid_q;
    logic                 done_q;

    // accept edge uses the live config so the first read leaves next cycle
    always_comb begin
        accept    = (state_q == IDLE) && start;
        base_e    = accept ? tid_base     : base_q;
        count_e   = accept ? tid_count    : count_q;
        lat_e     = accept ? cgra_latency : lat_q;
        rd_mask_e = accept ? port_rd_mask : rd_mask_q;
        wr_mask_e = accept ? port_wr_mask : wr_mask_q;
        idx_e     = accept ? '0 : idx_q;
        step      = !stall && (accept || state_q == ISSUE || state_q == DRAIN);
        issuing   = step && (accept ? (tid_count != '0) : (state_q == ISSUE));
        push.valid = issuing;
        push.tid   = tid_wrap(base_e, idx_e);
    end

    dice_tid_delay_line #(
        .MAX_CGRA_LATENCY(MAX_CGRA_LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr || (state_q == DONE)),
        .shift_en(step),
        .push    (push),
        .lat     (lat_e),
        .tap     (tap)
    );

    // writeback, in-flight tracking and next-state selection
    always_comb begin
        wb      = step && tap.valid;
        infl_d  = infl_q + INFW'(issuing) - INFW'(wb);
        last    = issuing && ((idx_e + tid_cnt_t'(1)) == count_e);
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (tid_count == '0) ? DONE : ISSUE;
            ISSUE: state_d = ISSUE;
            DRAIN: if (infl_d == '0) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
        if (last) begin
            state_d = (infl_d == '0) ? DONE : DRAIN;
        end
    end

    // state, counters and registered port outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            infl_q   <= '0;
            rd_en_q  <= '0;
            wr_en_q  <= '0;
            rd_tid_q <= '0;
            wr_tid_q <= '0;
            done_q   <= 1'b0;
        end else if (clr) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            infl_q   <= '0;
            rd_en_q  <= '0;
            wr_en_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            infl_q  <= infl_d;
            done_q  <= (state_q == DONE);
            if (accept || issuing) begin
                idx_q <= idx_e + tid_cnt_t'(issuing);
            end
            rd_en_q <= issuing ? rd_mask_e : '0;
            if (issuing) begin
                rd_tid_q <= push.tid;
            end
            wr_en_q <= wb ? wr_mask_e : '0;
            if (wb) begin
                wr_tid_q <= tap.tid;
            end
        end
    end

    // dispatch config captured once per accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q    <= '0;
            count_q   <= '0;
            lat_q     <= '0;
            rd_mask_q <= '0;
            wr_mask_q <= '0;
        end else if (accept && !clr) begin
            base_q    <= tid_base;
            count_q   <= tid_count;
            lat_q     <= cgra_latency;
            rd_mask_q <= port_rd_mask;
            wr_mask_q <= port_wr_mask;
        end
    end

    assign rd_en  = rd_en_q;
    assign wr_en  = wr_en_q;
    assign rd_tid = {NUM_PORTS{rd_tid_q}};
    assign wr_tid = {NUM_PORTS{wr_tid_q}};
    assign busy   = (state_q == ISSUE) || (state_q == DRAIN);
    assign done   = done_q;

    a_count_legal: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (tid_count <= tid_cnt_t'(NUM_TID)));

    a_lat_legal: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (cgra_latency <= LATW'(MAX_CGRA_LATENCY)));

endmodule

// File: tb/tb_dice_pred_rf_tid_sequencer.sv
// Randomized bench for the TID sequencer against a queue-based model.
// Model tracks due times in non-stalled steps per dispatch.
module tb_dice_pred_rf_tid_sequencer;

    localparam int NP = 16;
    localparam int NT = 512;
    localparam int AW = 9;
    localparam int LW = 6;
    localparam int LIMIT = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic [AW-1:0] tid_base = '0;
    logic [AW:0]   tid_count = '0;
    logic [LW-1:0] cgra_latency = '0;
    logic [NP-1:0] port_rd_mask = '0;
    logic [NP-1:0] port_wr_mask = '0;
    logic [NP-1:0] rd_en, wr_en;
    logic [NP*AW-1:0] rd_tid, wr_tid;
    logic busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    // model: 0 idle, 1 running, 2 done pending
    int m_phase = 0;
    int m_base, m_cnt, m_lat, m_issued, m_step;
    logic [NP-1:0] m_rm, m_wm;
    int q_due[$];
    int q_tid[$];
    logic [NP-1:0] e_rd_en = '0, e_wr_en = '0;
    int e_rd_tid = 0, e_wr_tid = 0;
    logic e_done = 1'b0;

    dice_pred_rf_tid_sequencer dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
        .tid_base(tid_base), .tid_count(tid_count),
        .cgra_latency(cgra_latency),
        .port_rd_mask(port_rd_mask), .port_wr_mask(port_wr_mask),
        .stall(stall), .rd_en(rd_en), .rd_tid(rd_tid),
        .wr_en(wr_en), .wr_tid(wr_tid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [NP*AW-1:0] rep(int t);
        logic [NP*AW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*AW +: AW] = AW'(t);
        return v;
    endfunction

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int t;
        e_rd_en = '0;
        e_wr_en = '0;
        e_done  = 1'b0;
        if (!rst_n) begin
            m_phase = 0;
            e_rd_tid = 0;
            e_wr_tid = 0;
            q_due.delete();
            q_tid.delete();
        end else if (clr) begin
            m_phase = 0;
            q_due.delete();
            q_tid.delete();
        end else if (m_phase == 2) begin
            e_done = 1'b1;
            m_phase = 0;
        end else begin
            if (m_phase == 0 && start) begin
                m_base = int'(tid_base);
                m_cnt = int'(tid_count);
                m_lat = int'(cgra_latency);
                m_rm = port_rd_mask;
                m_wm = port_wr_mask;
                m_issued = 0;
                m_step = 0;
                q_due.delete();
                q_tid.delete();
                m_phase = (m_cnt == 0) ? 2 : 1;
            end
            if (m_phase == 1 && !stall) begin
                m_step++;
                if (m_issued < m_cnt) begin
                    t = (m_base + m_issued) % NT;
                    e_rd_en = m_rm;
                    e_rd_tid = t;
                    q_due.push_back(m_step + m_lat);
                    q_tid.push_back(t);
                    m_issued++;
                end
                if (q_due.size() > 0 && q_due[0] == m_step) begin
                    e_wr_en = m_wm;
                    e_wr_tid = q_tid.pop_front();
                    void'(q_due.pop_front());
                end
                if (m_issued == m_cnt && q_due.size() == 0) m_phase = 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("rd_en", rd_en, e_rd_en);
        chk("wr_en", wr_en, e_wr_en);
        chk("rd_tid", rd_tid, rep(e_rd_tid));
        chk("wr_tid", wr_tid, rep(e_wr_tid));
        chk("busy", busy, m_phase == 1);
        chk("done", done, e_done);
    endtask

    task automatic dispatch(int base, int cnt, int lat,
                            logic [NP-1:0] rm, logic [NP-1:0] wm,
                            int st_at, int st_len, int st_pct,
                            int clr_at, int rst_at);
        int n;
        n = 0;
        tid_base = AW'(base);
        tid_count = (AW+1)'(cnt);
        cgra_latency = LW'(lat);
        port_rd_mask = rm;
        port_wr_mask = wm;
        stall = 1'b0;
        start = 1'b1;
        tick();
        while (m_phase != 0 && n < LIMIT) begin
            n++;
            stall = (n >= st_at && n < st_at + st_len) ||
                    ($urandom_range(99) < st_pct);
            clr = (n == clr_at);
            rst_n = !(n == rst_at);
            start = ($urandom_range(3) == 0);
            tid_base = AW'($urandom_range(NT - 1));
            tid_count = (AW+1)'($urandom_range(20));
            cgra_latency = LW'($urandom_range(32));
            port_rd_mask = NP'($urandom);
            port_wr_mask = NP'($urandom);
            tick();
        end
        stall = 1'b0;
        clr = 1'b0;
        rst_n = 1'b1;
        start = 1'b0;
        chk("timeout", n < LIMIT, 1);
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        dispatch(0, 4, 3, '1, '1, -1, 0, 0, -1, -1);
        dispatch(510, 4, 0, '1, '1, -1, 0, 0, -1, -1);
        dispatch(8, 3, 2, '1, '1, 2, 2, 0, -1, -1);
        dispatch(100, 16, 5, '1, '1, -1, 0, 0, 6, -1);
        dispatch(3, 0, 7, '1, '1, -1, 0, 0, -1, -1);
        dispatch(20, 6, 4, 16'h0003, 16'h8000, -1, 0, 0, -1, -1);
        dispatch(40, 4, 20, '1, '1, -1, 0, 0, -1, 10);
        dispatch(int'($urandom_range(NT - 1)), NT, 32, '1, '1,
                 -1, 0, 10, -1, -1);
        for (int k = 0; k < 40; k++) begin
            dispatch(int'($urandom_range(NT - 1)),
                     int'($urandom_range(40)),
                     int'($urandom_range(32)),
                     NP'($urandom), NP'($urandom),
                     -1, 0, int'($urandom_range(30)),
                     ($urandom_range(7) == 0) ? int'($urandom_range(1, 30)) : -1,
                     ($urandom_range(9) == 0) ? int'($urandom_range(1, 30)) : -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
